irq_ctrl: RTL and testbench
===========================

IRQ_CTRL -- requirements
Module: irq_ctrl

Interface
REQ-001 SHALL have port clk, input, 1: system clock; all state changes on posedge clk.
REQ-002 SHALL have port reset_n, input, 1: asynchronous, active-low reset.
REQ-003 SHALL have port clk_ce, input, 1: clock enable; no state change when low.
REQ-004 SHALL have ports bus_write/bus_read (input, 1), bus_address_in (input, 24), bus_data_in (input, 8), bus_data_out (output, 8): CPU register bus.
REQ-005 SHALL have port irq_sources, input, 16: one-clk_ce-cycle event pulses; timer256 irqs[3:0] drive bits [3:0].
REQ-006 SHALL have port cpu_mask, input, 2: CPU interrupt level; a request requires priority > cpu_mask.
REQ-007 SHALL have ports irq_req (output, 1), irq_vector (output, 4), irq_prio (output, 2): registered request to CPU.
REQ-008 SHALL have port irq_ack, input, 1: one-cycle CPU acknowledge of the current request.

Function
REQ-009 Registers SHALL be: 0x2020 PRIO (2 bits per group of 4 sources; group g at bits [2g+1:2g]; 0 = group masked); 0x2023/0x2024 ENABLE[7:0]/[15:8]; 0x2027/0x2028 PENDING[7:0]/[15:8].
REQ-010 Reads SHALL be combinational from bus_address_in; unmapped addresses return 0x00.
REQ-011 Writes SHALL apply on the clk_ce cycle with bus_write high; PRIO/ENABLE load data, PENDING is write-1-to-clear.
REQ-012 Pending bit SHALL set on its source pulse regardless of ENABLE; a set and a clear in the same cycle SHALL leave the bit set.
REQ-013 A source SHALL be eligible when pending, enabled, and its group priority > cpu_mask.
REQ-014 Arbitration SHALL pick the highest group priority, ties broken by lowest source index.
REQ-015 FSM SHALL have states IDLE, REQ, SERVICE.
REQ-016 IDLE: if any source is eligible, latch vector/prio and go to REQ; irq_req rises on that transition.
REQ-017 REQ: vector and prio SHALL be frozen (no preemption); on irq_ack go to SERVICE and drop irq_req.
REQ-018 REQ: if the latched source's pending bit is cleared or it becomes ineligible, SHALL return to IDLE and drop irq_req without ack.
REQ-019 SERVICE: when the latched source's pending bit is clear, SHALL return to IDLE; re-arbitration starts the next cycle.
REQ-020 irq_ack outside REQ SHALL be ignored.
REQ-021 Latency: source pulse in cycle N -> PENDING readable in N+1 -> irq_req high in N+2, under continuous clk_ce.
REQ-022 irq_vector/irq_prio SHALL hold their last latched values when irq_req is low.

Reset
REQ-023 While reset_n is low, PRIO, ENABLE and PENDING SHALL be 0x00, FSM IDLE, irq_req 0, irq_vector 0, irq_prio 0, regardless of clk.
REQ-024 Reset asserted mid-request SHALL drop irq_req immediately and discard the pending event.

Configuration
REQ-025 With IRQ_CTRL_NMI_EN defined, source 0 SHALL be non-maskable: it ignores ENABLE, PRIO and cpu_mask, wins arbitration over all sources, and reports irq_prio=3.
REQ-026 Without IRQ_CTRL_NMI_EN, source 0 SHALL behave as an ordinary group-0 source.

Verification
REQ-027 PRIO=0x01, ENABLE=0x0001, cpu_mask=0, pulse source 0 at cycle N -> irq_req=1 at N+2, vector=0, prio=1; PENDING[7:0] reads 0x01.
REQ-028 PRIO=0x09 (group0=1, group1=2), enable sources 1 and 5, pulse both in one cycle -> vector=5, prio=2; ack, write 0x20 to 0x2027 -> SERVICE->IDLE, then vector=1 issued.
REQ-029 In REQ with vector=3, write 0x08 to 0x2027 before ack -> irq_req drops next cycle, FSM IDLE.
REQ-030 Same-cycle source 2 pulse and write 0x04 to 0x2027 -> PENDING[2]=1.
REQ-031 cpu_mask=2, group priority 2, source pending -> no irq_req; set cpu_mask=1 -> irq_req rises next cycle.
REQ-032 Assert reset_n low while irq_req=1 -> irq_req=0 and all registers 0x00 with no clock edge; with IRQ_CTRL_NMI_EN defined, ENABLE=0, pulse source 0 -> irq_req, vector=0, prio=3.

Source files
------------

// File: rtl/irq_ctrl_if.sv
// rtl/irq_ctrl_if.sv - CPU register bus bundle for the interrupt controller
interface irq_ctrl_if;
  logic        bus_write;
  logic        bus_read;
  logic [23:0] bus_address_in;
  logic [7:0]  bus_data_in;
  logic [7:0]  bus_data_out;

  modport master (
    output bus_write, bus_read, bus_address_in, bus_data_in,
    input  bus_data_out
  );

  modport slave (
    input  bus_write, bus_read, bus_address_in, bus_data_in,
    output bus_data_out
  );
endinterface

// File: rtl/irq_ctrl.sv
// rtl/irq_ctrl.sv - 16-source prioritised interrupt controller with registered CPU request
// Optional feature: define IRQ_CTRL_NMI_EN to make source 0 non-maskable.
module irq_ctrl (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        clk_ce,
  irq_ctrl_if.slave   bus,
  input  logic [15:0] irq_sources,
  input  logic [1:0]  cpu_mask,
  output logic        irq_req,
  output logic [3:0]  irq_vector,
  output logic [1:0]  irq_prio,
  input  logic        irq_ack
);

  localparam logic [23:0] ADDR_PRIO    = 24'h002020;
  localparam logic [23:0] ADDR_EN_LO   = 24'h002023;
  localparam logic [23:0] ADDR_EN_HI   = 24'h002024;
  localparam logic [23:0] ADDR_PEND_LO = 24'h002027;
  localparam logic [23:0] ADDR_PEND_HI = 24'h002028;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_REQ     = 2'd1;
  localparam logic [1:0] S_SERVICE = 2'd2;

  logic [7:0]  r_prio;
  logic [15:0] r_enable;
  logic [15:0] r_pending;
  logic [1:0]  r_state;
  logic        r_irq_req;
  logic [3:0]  r_vector;
  logic [1:0]  r_irq_prio;

  logic [15:0] w_clr;
  logic [15:0] w_pending_nxt;
  logic [15:0] w_qual;
  logic [15:0] w_elig;
  logic [1:0]  w_eff_prio [16];
  logic        w_any;
  logic [3:0]  w_best_vec;
  logic [1:0]  w_best_prio;
  logic        w_latched_ok;
  logic [7:0]  w_rdata;

  always_comb begin
    w_clr = 16'h0000;
    if (bus.bus_write) begin
      if (bus.bus_address_in == ADDR_PEND_LO) w_clr = {8'h00, bus.bus_data_in};
      if (bus.bus_address_in == ADDR_PEND_HI) w_clr = {bus.bus_data_in, 8'h00};
    end
  end

  // A source pulse wins over a same-cycle write-1-to-clear.
  assign w_pending_nxt = (r_pending & ~w_clr) | irq_sources;

  always_comb begin
    for (int i = 0; i < 16; i++) begin
      w_eff_prio[i] = r_prio[2*(i/4) +: 2];
      w_qual[i]     = r_enable[i] && (w_eff_prio[i] > cpu_mask);
    end
`ifdef IRQ_CTRL_NMI_EN
    w_eff_prio[0] = 2'd3;
    w_qual[0]     = 1'b1;
`endif
  end

  assign w_elig = r_pending & w_qual;

  // Descending scan with >= lets the lowest index win a priority tie.
  always_comb begin
    w_any       = 1'b0;
    w_best_vec  = 4'd0;
    w_best_prio = 2'd0;
    for (int i = 15; i >= 0; i--) begin
      if (w_elig[i] && (!w_any || (w_eff_prio[i] >= w_best_prio))) begin
        w_any       = 1'b1;
        w_best_vec  = 4'(i);
        w_best_prio = w_eff_prio[i];
      end
    end
  end

  assign w_latched_ok = w_pending_nxt[r_vector] && w_qual[r_vector];

  always_comb begin
    case (bus.bus_address_in)
      ADDR_PRIO:    w_rdata = r_prio;
      ADDR_EN_LO:   w_rdata = r_enable[7:0];
      ADDR_EN_HI:   w_rdata = r_enable[15:8];
      ADDR_PEND_LO: w_rdata = r_pending[7:0];
      ADDR_PEND_HI: w_rdata = r_pending[15:8];
      default:      w_rdata = 8'h00;
    endcase
  end

  assign bus.bus_data_out = w_rdata;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_prio    <= 8'h00;
      r_enable  <= 16'h0000;
      r_pending <= 16'h0000;
    end else if (clk_ce) begin
      r_pending <= w_pending_nxt;
      if (bus.bus_write) begin
        if (bus.bus_address_in == ADDR_PRIO)  r_prio          <= bus.bus_data_in;
        if (bus.bus_address_in == ADDR_EN_LO) r_enable[7:0]   <= bus.bus_data_in;
        if (bus.bus_address_in == ADDR_EN_HI) r_enable[15:8]  <= bus.bus_data_in;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= S_IDLE;
      r_irq_req  <= 1'b0;
      r_vector   <= 4'd0;
      r_irq_prio <= 2'd0;
    end else if (clk_ce) begin
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_vector   <= w_best_vec;
            r_irq_prio <= w_best_prio;
            r_irq_req  <= 1'b1;
            r_state    <= S_REQ;
          end
        end
        S_REQ: begin
          if (irq_ack) begin
            r_irq_req <= 1'b0;
            r_state   <= S_SERVICE;
          end else if (!w_latched_ok) begin
            r_irq_req <= 1'b0;
            r_state   <= S_IDLE;
          end
        end
        S_SERVICE: begin
          if (!r_pending[r_vector]) r_state <= S_IDLE;
        end
        default: begin
          r_irq_req <= 1'b0;
          r_state   <= S_IDLE;
        end
      endcase
    end
  end

  assign irq_req    = r_irq_req;
  assign irq_vector = r_vector;
  assign irq_prio   = r_irq_prio;

endmodule

// File: tb/tb_irq_ctrl.sv
// tb/tb_irq_ctrl.sv - directed self-checking bench for irq_ctrl
module tb_irq_ctrl;
  logic        clk;
  logic        reset_n;
  logic        clk_ce;
  logic [15:0] irq_sources;
  logic [1:0]  cpu_mask;
  logic        irq_req;
  logic [3:0]  irq_vector;
  logic [1:0]  irq_prio;
  logic        irq_ack;
  int          n_assert;
  int          n_fail;

  irq_ctrl_if bus ();

  irq_ctrl dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .clk_ce      (clk_ce),
    .bus         (bus),
    .irq_sources (irq_sources),
    .cpu_mask    (cpu_mask),
    .irq_req     (irq_req),
    .irq_vector  (irq_vector),
    .irq_prio    (irq_prio),
    .irq_ack     (irq_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [23:0] addr, input logic [7:0] data);
    bus.bus_write      = 1'b1;
    bus.bus_address_in = addr;
    bus.bus_data_in    = data;
    cyc();
    bus.bus_write      = 1'b0;
  endtask

  task automatic rd(input logic [23:0] addr, output logic [7:0] data);
    bus.bus_read       = 1'b1;
    bus.bus_address_in = addr;
    #1;
    data               = bus.bus_data_out;
    bus.bus_read       = 1'b0;
  endtask

  task automatic pulse(input logic [15:0] src);
    irq_sources = src;
    cyc();
    irq_sources = 16'h0000;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    cyc();
    reset_n = 1'b1;
  endtask

  initial begin
    logic [7:0] d;
    n_assert = 0;
    n_fail   = 0;
    reset_n  = 1'b0;
    clk_ce   = 1'b1;
    irq_sources = 16'h0000;
    cpu_mask = 2'd0;
    irq_ack  = 1'b0;
    bus.bus_write      = 1'b0;
    bus.bus_read       = 1'b0;
    bus.bus_address_in = 24'h0;
    bus.bus_data_in    = 8'h00;

    // reset state, checked before any clock edge
    #2;
    chk("rst_irq_req", 16'(irq_req), 16'h0);
    chk("rst_vector", 16'(irq_vector), 16'h0);
    chk("rst_prio", 16'(irq_prio), 16'h0);
    rd(24'h002020, d); chk("rst_PRIO", 16'(d), 16'h00);
    rd(24'h002027, d); chk("rst_PEND_LO", 16'(d), 16'h00);
    cyc();
    reset_n = 1'b1;

    // register readback and unmapped address
    wr(24'h002020, 8'hA5);
    wr(24'h002024, 8'h3C);
    rd(24'h002020, d); chk("rd_PRIO", 16'(d), 16'hA5);
    rd(24'h002024, d); chk("rd_EN_HI", 16'(d), 16'h3C);
    rd(24'h002021, d); chk("rd_unmapped", 16'(d), 16'h00);
    do_reset();

    // clock enable low: no writes, no pending capture
    clk_ce = 1'b0;
    wr(24'h002020, 8'hFF);
    pulse(16'h0001);
    rd(24'h002020, d); chk("ce_PRIO", 16'(d), 16'h00);
    rd(24'h002027, d); chk("ce_PEND", 16'(d), 16'h00);
    clk_ce = 1'b1;

    // basic latency
    wr(24'h002020, 8'h01);
    wr(24'h002023, 8'h01);
    pulse(16'h0001);
    rd(24'h002027, d); chk("lat_PEND_N1", 16'(d), 16'h01);
    chk("lat_req_N1", 16'(irq_req), 16'h0);
    cyc();
    chk("lat_req_N2", 16'(irq_req), 16'h1);
    chk("lat_vec", 16'(irq_vector), 16'h0);
    chk("lat_prio", 16'(irq_prio), 16'h1);
    do_reset();

    // priority between groups, ack, service, re-arbitration
    wr(24'h002020, 8'h09);
    wr(24'h002023, 8'h22);
    pulse(16'h0022);
    cyc();
    chk("arb_req", 16'(irq_req), 16'h1);
    chk("arb_vec", 16'(irq_vector), 16'h5);
    chk("arb_prio", 16'(irq_prio), 16'h2);
    irq_ack = 1'b1;
    cyc();
    irq_ack = 1'b0;
    chk("ack_req_low", 16'(irq_req), 16'h0);
    chk("ack_vec_hold", 16'(irq_vector), 16'h5);
    cyc();
    chk("svc_no_rearb", 16'(irq_req), 16'h0);
    wr(24'h002027, 8'h20);
    cyc();
    chk("svc_to_idle", 16'(irq_req), 16'h0);
    cyc();
    chk("rearb_req", 16'(irq_req), 16'h1);
    chk("rearb_vec", 16'(irq_vector), 16'h1);
    chk("rearb_prio", 16'(irq_prio), 16'h1);
    do_reset();

    // tie within a group -> lowest index; high-byte source
    wr(24'h002020, 8'h04);
    wr(24'h002023, 8'h50);
    pulse(16'h0050);
    cyc();
    chk("tie_vec", 16'(irq_vector), 16'h4);
    do_reset();
    wr(24'h002020, 8'hC0);
    wr(24'h002024, 8'h10);
    pulse(16'h1000);
    rd(24'h002028, d); chk("hi_PEND", 16'(d), 16'h10);
    cyc();
    chk("hi_vec", 16'(irq_vector), 16'hC);
    chk("hi_prio", 16'(irq_prio), 16'h3);
    do_reset();

    // clear before ack withdraws the request
    wr(24'h002020, 8'h01);
    wr(24'h002023, 8'h08);
    pulse(16'h0008);
    cyc();
    chk("wd_req", 16'(irq_req), 16'h1);
    chk("wd_vec", 16'(irq_vector), 16'h3);
    wr(24'h002027, 8'h08);
    chk("wd_drop", 16'(irq_req), 16'h0);
    cyc();
    chk("wd_idle", 16'(irq_req), 16'h0);
    chk("wd_vec_hold", 16'(irq_vector), 16'h3);
    do_reset();

    // set and clear in the same cycle keeps the bit
    pulse(16'h0004);
    irq_sources        = 16'h0004;
    wr(24'h002027, 8'h04);
    irq_sources        = 16'h0000;
    rd(24'h002027, d); chk("setclr_PEND", 16'(d), 16'h04);
    wr(24'h002027, 8'h04);
    rd(24'h002027, d); chk("w1c_PEND", 16'(d), 16'h00);
    do_reset();

    // cpu_mask gating, stray ack ignored in IDLE
    wr(24'h002020, 8'h02);
    wr(24'h002023, 8'h01);
    cpu_mask = 2'd2;
    pulse(16'h0001);
    irq_ack = 1'b1;
    cyc();
    irq_ack = 1'b0;
    cyc();
    chk("mask_no_req", 16'(irq_req), 16'h0);
    cpu_mask = 2'd1;
    cyc();
    chk("mask_req", 16'(irq_req), 16'h1);
    chk("mask_prio", 16'(irq_prio), 16'h2);

    // asynchronous reset mid-request
    reset_n = 1'b0;
    #1;
    chk("arst_req", 16'(irq_req), 16'h0);
    chk("arst_prio", 16'(irq_prio), 16'h0);
    rd(24'h002020, d); chk("arst_PRIO", 16'(d), 16'h00);
    rd(24'h002023, d); chk("arst_EN", 16'(d), 16'h00);
    rd(24'h002027, d); chk("arst_PEND", 16'(d), 16'h00);
    cyc();
    reset_n  = 1'b1;
    cpu_mask = 2'd0;
    cyc();
    cyc();
    chk("arst_discard", 16'(irq_req), 16'h0);

    // source 0 with ENABLE=0, PRIO=0, cpu_mask=3
    cpu_mask = 2'd3;
    pulse(16'h0001);
    cyc();
`ifdef IRQ_CTRL_NMI_EN
    chk("nmi_req", 16'(irq_req), 16'h1);
    chk("nmi_vec", 16'(irq_vector), 16'h0);
    chk("nmi_prio", 16'(irq_prio), 16'h3);
`else
    chk("src0_masked", 16'(irq_req), 16'h0);
    rd(24'h002027, d); chk("src0_PEND", 16'(d), 16'h01);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
